// File: rtl/mem_bus_ctrl_if.sv
// Single-master Wishbone-style data bus between the MEM-stage controller and the data slave.
// Signal names carry the bus-side direction as seen from the master.
interface mem_bus_if #(
  parameter int DATA_W = 32
);
  logic              bus_cyc_o;
  logic              bus_stb_o;
  logic              bus_we_o;
  logic [DATA_W-1:0] bus_adr_o;
  logic [DATA_W-1:0] bus_dat_o;
  logic [3:0]        bus_sel_o;
  logic              bus_ack_i;
  logic              bus_err_i;
  logic [DATA_W-1:0] bus_dat_i;

  modport master (
    output bus_cyc_o, bus_stb_o, bus_we_o, bus_adr_o, bus_dat_o, bus_sel_o,
    input  bus_ack_i, bus_err_i, bus_dat_i
  );

  modport slave (
    input  bus_cyc_o, bus_stb_o, bus_we_o, bus_adr_o, bus_dat_o, bus_sel_o,
    output bus_ack_i, bus_err_i, bus_dat_i
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// MEM-stage load/store sequencer: issues one bus cycle per request, stalls the pipeline
// until it completes, and buffers load data while another stall source holds the pipeline.
module mem_bus_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [3:0]        mem_sel,
  input  logic              stall_in,
  input  logic              flush,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_err,
  output logic              stallreq,
  mem_bus_if.master         bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] rd_buf;
  logic [TO_W-1:0]   to_cnt;
  logic              timeout_hit;
  logic              abort;

  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT - 1));
  // A slave error always aborts; the timeout only when the slave stays silent this cycle.
  assign abort = bus.bus_err_i | (!bus.bus_ack_i & timeout_hit);

  always_comb begin
    stallreq  = 1'b0;
    mem_rdata = '0;
    case (state)
      IDLE: stallreq = mem_req & !flush;
      BUSY: begin
        stallreq  = !bus.bus_ack_i | bus.bus_err_i | flush;
        mem_rdata = bus.bus_dat_i;
      end
      HOLD: mem_rdata = rd_buf;
      default: begin
        stallreq  = 1'b0;
        mem_rdata = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      rd_buf        <= '0;
      to_cnt        <= '0;
      mem_err       <= 1'b0;
      bus.bus_cyc_o <= 1'b0;
      bus.bus_stb_o <= 1'b0;
      bus.bus_we_o  <= 1'b0;
      bus.bus_adr_o <= '0;
      bus.bus_dat_o <= '0;
      bus.bus_sel_o <= '0;
    end else begin
      mem_err <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req && !flush) begin
            bus.bus_we_o  <= mem_we;
            bus.bus_adr_o <= mem_addr;
            bus.bus_dat_o <= mem_wdata;
            bus.bus_sel_o <= mem_sel;
            bus.bus_cyc_o <= 1'b1;
            bus.bus_stb_o <= 1'b1;
            to_cnt        <= '0;
            state         <= BUSY;
          end
        end
        BUSY: begin
          if (flush) begin
            bus.bus_cyc_o <= 1'b0;
            bus.bus_stb_o <= 1'b0;
            state         <= IDLE;
          end else if (abort) begin
            bus.bus_cyc_o <= 1'b0;
            bus.bus_stb_o <= 1'b0;
            mem_err       <= 1'b1;
            state         <= IDLE;
          end else if (bus.bus_ack_i) begin
            rd_buf        <= bus.bus_dat_i;
            bus.bus_cyc_o <= 1'b0;
            bus.bus_stb_o <= 1'b0;
            state         <= stall_in ? HOLD : IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        // The instruction that owns rd_buf is still in MEM, so mem_req is ignored here.
        HOLD: begin
          if (!stall_in || flush) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: a driver (which also plays the bus slave) queues the
// expected outcome of each transaction, and a monitor checks what the DUT actually does.
module tb_mem_bus_ctrl;
  localparam int DW      = 32;
  localparam int TIMEOUT = 4;

  localparam int R_ACK    = 0;
  localparam int R_ERR    = 1;
  localparam int R_ACKERR = 2;
  localparam int R_NONE   = 3;

  localparam int O_DONE  = 0;
  localparam int O_ERR   = 1;
  localparam int O_FLUSH = 2;

  typedef struct {
    logic          we;
    logic [DW-1:0] adr;
    logic [DW-1:0] dat;
    logic [3:0]    sel;
    int            outcome;
    logic [DW-1:0] rdata;
    int            len;
    int            hold_n;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          mem_req, mem_we, stall_in, flush;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]    mem_sel;
  logic          mem_err, stallreq;

  mem_bus_if #(.DATA_W(DW)) bus_if ();

  mem_bus_ctrl #(.DATA_W(DW), .TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .stall_in(stall_in), .flush(flush),
    .mem_rdata(mem_rdata), .mem_err(mem_err), .stallreq(stallreq),
    .bus(bus_if)
  );

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  logic mon_en = 1'b0;
  logic have_cur = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  // Expected behaviour derived from the transaction description, then the cycle-level drive.
  task automatic run_txn(input logic we, input logic [DW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [3:0] sel, input int resp, input int w, input int f,
                         input int hold_n, input logic [DW-1:0] rdat);
    exp_t e;
    int   end_k;
    e.we = we; e.adr = adr; e.dat = dat; e.sel = sel; e.rdata = rdat;
    end_k = (resp == R_NONE) ? TIMEOUT - 1 : w;
    if (f >= 0 && f <= end_k) begin
      e.outcome = O_FLUSH; e.len = f + 1; end_k = f;
    end else if (resp == R_ACK) begin
      e.outcome = O_DONE;  e.len = w + 1;
    end else begin
      e.outcome = O_ERR;   e.len = end_k + 1;
    end
    e.hold_n = (e.outcome == O_DONE) ? hold_n : 0;
    exp_q.push_back(e);

    mem_req = 1'b1; mem_we = we; mem_addr = adr; mem_wdata = dat; mem_sel = sel;
    flush = 1'b0; stall_in = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k <= end_k; k++) begin
      flush = (k == f);
      bus_if.bus_ack_i = (resp == R_ACK || resp == R_ACKERR) && (k == w);
      bus_if.bus_err_i = (resp == R_ERR || resp == R_ACKERR) && (k == w);
      bus_if.bus_dat_i = (k == w) ? rdat : DW'($urandom);
      stall_in = (k == end_k) ? (e.hold_n > 0) : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    bus_if.bus_ack_i = 1'b0; bus_if.bus_err_i = 1'b0; flush = 1'b0;
    if (e.hold_n > 0) begin
      for (int i = 0; i < e.hold_n - 1; i++) begin
        stall_in = 1'b1;
        @(posedge clk); #1;
      end
      stall_in = 1'b0;
      @(posedge clk); #1;
    end
    mem_req = 1'b0; stall_in = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      mem_req = 1'($urandom_range(0, 1));
      flush = mem_req;
      mem_addr = DW'($urandom);
      @(posedge clk); #1;
    end
    mem_req = 1'b0; flush = 1'b0;
  endtask

  // Monitor: matches every bus cycle the DUT opens against the next queued expectation.
  initial begin : monitor
    exp_t cur;
    logic prev_cyc = 1'b0;
    logic done_seen = 1'b0;
    logic fell;
    int   cyc_len = 0;
    int   hold_left = 0;
    int   obs;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_cyc = 1'b0; have_cur = 1'b0; hold_left = 0; done_seen = 1'b0;
      end else begin
        fell = 1'b0;
        if (bus_if.bus_cyc_o && !prev_cyc) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_cycle: got cyc=1 adr=%h required no bus cycle", bus_if.bus_adr_o);
            have_cur = 1'b0;
          end else begin
            cur = exp_q.pop_front();
            have_cur = 1'b1; cyc_len = 0; done_seen = 1'b0;
            chk("issue_we",  DW'(bus_if.bus_we_o),  DW'(cur.we));
            chk("issue_adr", bus_if.bus_adr_o,      cur.adr);
            chk("issue_dat", bus_if.bus_dat_o,      cur.dat);
            chk("issue_sel", DW'(bus_if.bus_sel_o), DW'(cur.sel));
            chk("issue_stb", DW'(bus_if.bus_stb_o), DW'(1));
          end
        end
        if (bus_if.bus_cyc_o && have_cur) begin
          cyc_len++;
          if (!stallreq && !done_seen) begin
            done_seen = 1'b1;
            chk("ack_rdata", mem_rdata, cur.rdata);
          end
        end
        if (!bus_if.bus_cyc_o && prev_cyc && have_cur) begin
          fell = 1'b1;
          obs = mem_err ? O_ERR : (done_seen ? O_DONE : O_FLUSH);
          chk("outcome", DW'(obs), DW'(cur.outcome));
          chk("busy_len", DW'(cyc_len), DW'(cur.len));
          hold_left = done_seen ? cur.hold_n : 0;
          have_cur = 1'b0;
        end
        if (!fell) chk("err_quiet", DW'(mem_err), DW'(0));
        if (!bus_if.bus_cyc_o) begin
          if (hold_left > 0) begin
            chk("hold_rdata", mem_rdata, cur.rdata);
            chk("hold_stall", DW'(stallreq), DW'(0));
            hold_left--;
          end else begin
            chk("idle_rdata", mem_rdata, DW'(0));
            chk("idle_stall", DW'(stallreq), DW'(mem_req & !flush));
          end
        end
        prev_cyc = bus_if.bus_cyc_o;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish required finish within time limit");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin : driver
    int resp, w, f, h;
    rst = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_sel = '0;
    stall_in = 1'b0; flush = 1'b0;
    bus_if.bus_ack_i = 1'b0; bus_if.bus_err_i = 1'b0; bus_if.bus_dat_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cyc",   DW'(bus_if.bus_cyc_o), DW'(0));
    chk("rst_stb",   DW'(bus_if.bus_stb_o), DW'(0));
    chk("rst_adr",   bus_if.bus_adr_o,      DW'(0));
    chk("rst_err",   DW'(mem_err),          DW'(0));
    chk("rst_rdata", mem_rdata,             DW'(0));
    chk("rst_stall", DW'(stallreq),         DW'(0));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    run_txn(1'b0, 32'h100, 32'h0, 4'hF, R_ACK, 0, -1, 0, 32'hDEADBEEF);
    run_txn(1'b1, 32'h204, 32'h12345678, 4'b1100, R_ACK, 3, -1, 0, 32'h0BADF00D);
    run_txn(1'b0, 32'h308, 32'h0, 4'hF, R_ACK, 1, -1, 3, 32'hCAFEF00D);
    run_txn(1'b0, 32'h40C, 32'h0, 4'hF, R_NONE, 0, -1, 0, 32'h0);
    run_txn(1'b0, 32'h510, 32'h0, 4'hF, R_ACK, 3, 1, 0, 32'h11111111);
    run_txn(1'b0, 32'h514, 32'h0, 4'h3, R_ACK, 0, -1, 0, 32'h22222222);
    run_txn(1'b1, 32'h618, 32'hA5A5A5A5, 4'hF, R_ACKERR, 1, -1, 0, 32'h33333333);
    run_txn(1'b0, 32'h71C, 32'h0, 4'hF, R_ERR, 2, -1, 0, 32'h44444444);
    idle_gap(3);

    for (int n = 0; n < 70; n++) begin
      resp = ($urandom_range(0, 9) < 6) ? R_ACK : int'($urandom_range(1, 3));
      w = int'($urandom_range(0, TIMEOUT - 1));
      f = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, TIMEOUT - 1)) : -1;
      h = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_txn(1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom), 4'($urandom),
              resp, w, f, h, DW'($urandom));
      idle_gap(int'($urandom_range(0, 2)));
    end

    // Asynchronous reset while a cycle is outstanding must drop the bus immediately.
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drain", DW'(exp_q.size() + int'(have_cur)), DW'(0));
    mon_en = 1'b0;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'hABC0; mem_wdata = 32'h5555AAAA; mem_sel = 4'hF;
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(posedge clk); #2;
    chk("pre_rst_cyc", DW'(bus_if.bus_cyc_o), DW'(1));
    rst = 1'b0;
    #1;
    chk("arst_cyc",   DW'(bus_if.bus_cyc_o), DW'(0));
    chk("arst_stb",   DW'(bus_if.bus_stb_o), DW'(0));
    chk("arst_we",    DW'(bus_if.bus_we_o),  DW'(0));
    chk("arst_adr",   bus_if.bus_adr_o,      DW'(0));
    chk("arst_dat",   bus_if.bus_dat_o,      DW'(0));
    chk("arst_sel",   DW'(bus_if.bus_sel_o), DW'(0));
    chk("arst_stall", DW'(stallreq),         DW'(0));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    mon_en = 1'b1;
    run_txn(1'b0, 32'h800, 32'h0, 4'hF, R_ACK, 2, -1, 0, 32'h87654321);
    repeat (3) @(posedge clk);
    #1;
    chk("final_drain", DW'(exp_q.size() + int'(have_cur)), DW'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
